i2c_rx_detect: RTL and testbench
================================

Name: i2c_rx_detect

Overview:
- Receive-side front end of the I2C slave.
- Samples raw SCL/SDA, detects START/STOP, and shifts in address and data bytes MSB-first on SCL rising edges.
- Flags the ACK bit window so the transmit-side output select can drive SDA low.
- Sits between the pad inputs and the slave controller FSM; it is the counterpart of the SDA output-select path.

Parameters:
- SLAVE_ADDR, 7'b1111000, 7-bit address this slave answers to.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- scl_in  input  1  raw SCL from pad (asynchronous)
- sda_in  input  1  raw SDA from pad (asynchronous)
- rx_data  output  8  last completed byte, MSB first
- byte_valid  output  1  one-cycle pulse: rx_data updated
- start_found  output  1  one-cycle pulse: START or repeated START detected
- stop_found  output  1  one-cycle pulse: STOP detected
- addr_match  output  1  level: current transaction addressed to SLAVE_ADDR
- rw_mode  output  1  level: R/W bit of last address byte (1 = master read)
- ack_window  output  1  level: bus is in the 9th-bit (ACK) period
- ack_sampled  output  1  one-cycle pulse: 9th bit sampled
- ack_value  output  1  SDA level sampled on 9th SCL rise (0 = ACK, 1 = NACK)

Behaviour:
- Synchronizers:
  - scl_in and sda_in each pass through 2 flops, reset to 1, giving scl_s and sda_s.
  - A third flop each holds scl_p and sda_p.
- Edge and condition terms (combinational):
  - scl_rise = scl_s & ~scl_p
  - scl_fall = ~scl_s & scl_p
  - start_c = scl_s & scl_p & sda_p & ~sda_s
  - stop_c = scl_s & scl_p & ~sda_p & sda_s
- Reset values:
  - All outputs 0, rx_data = 8'h00.
  - FSM = IDLE, bit counter = 0, shift register = 0.
  - rst asserted mid-transfer aborts immediately; no pulses are issued.
- FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK.
  - IDLE: ignores SCL edges; start_c -> ADDR.
  - ADDR / DATA:
    - On each scl_rise, shift sda_s into the LSB and increment bit_cnt (0..7).
    - On the 8th scl_rise, load rx_data from the shift result and set byte_valid high the next cycle.
    - At that 8th scl_rise, ADDR -> ADDR_ACK and DATA -> DATA_ACK.
    - On ADDR completion, update addr_match = (byte[7:1] == SLAVE_ADDR) and rw_mode = byte[0] in the same cycle rx_data updates.
  - ADDR_ACK / DATA_ACK:
    - ack_window rises on the first scl_fall after entry.
    - Next scl_rise: ack_value = sda_s, ack_sampled pulses for one cycle.
    - Following scl_fall: ack_window drops, bit_cnt = 0, go to DATA.
    - From ADDR_ACK with addr_match = 0: go to IDLE instead.
- Latency:
  - Pad edge to scl_rise/start_c/stop_c: 2–3 clk cycles (synchronizer).
  - Event to output pulse: 1 registered cycle.
- Priority (same cycle): stop_c > start_c > scl_rise.
- START or repeated START in any state:
  - start_found pulses, bit_cnt = 0, shift register cleared, addr_match = 0, go to ADDR.
  - A partial byte produces no byte_valid.
- STOP in any state:
  - stop_found pulses, addr_match = 0, ack_window = 0, go to IDLE.
  - A partial byte is discarded.
- A STOP while in IDLE still pulses stop_found.
- rx_data holds its value until the next completed byte; rw_mode holds until the next address byte.
- Pulses never last longer than one clk cycle, even if SCL is stretched.

Test Plan:
- START, address 0xF0 (1111000 + W), master ACKs -> start_found once, byte_valid with rx_data = 8'hF0, addr_match = 1, rw_mode = 0, ack_window high for the 9th clock only.
- Matched write, then data 0xA5, then STOP -> second byte_valid with rx_data = 8'hA5, ack_value = 0 pulse, stop_found, addr_match = 0, FSM in IDLE.
- Address 0x22 -> byte_valid with rx_data = 8'h22, addr_match = 0, no ack_window after the address byte; subsequent SCL activity ignored until the next START.
- Repeated START after 4 data bits, then address 0xF1 -> no byte_valid for the partial byte, start_found pulses, addr_match = 1, rw_mode = 1.
- Master NACK (SDA = 1 on 9th rise) after data 0x3C -> rx_data = 8'h3C, ack_sampled with ack_value = 1.
- rst asserted mid-byte, then released -> all outputs 0, FSM in IDLE; next START plus address decodes correctly.

Source files
------------

// File: rtl/i2c_rx_detect.sv
// I2C slave receive front end: pad synchronizers, START/STOP detection,
// byte shifting and ACK-window tracking.
module i2c_rx_detect #(
    parameter logic [6:0] SLAVE_ADDR = 7'b1111000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic [7:0] rx_data,
    output logic       byte_valid,
    output logic       start_found,
    output logic       stop_found,
    output logic       addr_match,
    output logic       rw_mode,
    output logic       ack_window,
    output logic       ack_sampled,
    output logic       ack_value
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        DATA     = 3'd3,
        DATA_ACK = 3'd4
    } state_t;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic       ack_done;

    logic scl_m, scl_s, scl_p;
    logic sda_m, sda_s, sda_p;

    logic       scl_rise;
    logic       scl_fall;
    logic       start_c;
    logic       stop_c;
    logic [7:0] shift_nxt;

    // Two-flop synchronizers plus one history flop per line; idle bus is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_m <= 1'b1;
            scl_s <= 1'b1;
            scl_p <= 1'b1;
            sda_m <= 1'b1;
            sda_s <= 1'b1;
            sda_p <= 1'b1;
        end else begin
            scl_m <= scl_in;
            scl_s <= scl_m;
            scl_p <= scl_s;
            sda_m <= sda_in;
            sda_s <= sda_m;
            sda_p <= sda_s;
        end
    end

    // Edge and bus-condition terms from the synchronized lines.
    always_comb begin
        scl_rise  = scl_s & ~scl_p;
        scl_fall  = ~scl_s & scl_p;
        start_c   = scl_s & scl_p & sda_p & ~sda_s;
        stop_c    = scl_s & scl_p & ~sda_p & sda_s;
        shift_nxt = {shift[6:0], sda_s};
    end

    // Receive FSM; STOP beats START beats ordinary SCL activity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= 3'd0;
            shift       <= 8'h00;
            ack_done    <= 1'b0;
            rx_data     <= 8'h00;
            byte_valid  <= 1'b0;
            start_found <= 1'b0;
            stop_found  <= 1'b0;
            addr_match  <= 1'b0;
            rw_mode     <= 1'b0;
            ack_window  <= 1'b0;
            ack_sampled <= 1'b0;
            ack_value   <= 1'b0;
        end else begin
            byte_valid  <= 1'b0;
            start_found <= 1'b0;
            stop_found  <= 1'b0;
            ack_sampled <= 1'b0;
            if (stop_c) begin
                stop_found <= 1'b1;
                addr_match <= 1'b0;
                ack_window <= 1'b0;
                ack_done   <= 1'b0;
                bit_cnt    <= 3'd0;
                shift      <= 8'h00;
                state      <= IDLE;
            end else if (start_c) begin
                start_found <= 1'b1;
                addr_match  <= 1'b0;
                ack_window  <= 1'b0;
                ack_done    <= 1'b0;
                bit_cnt     <= 3'd0;
                shift       <= 8'h00;
                state       <= ADDR;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    ADDR, DATA: begin
                        if (scl_rise) begin
                            shift <= shift_nxt;
                            if (bit_cnt == 3'd7) begin
                                bit_cnt    <= 3'd0;
                                rx_data    <= shift_nxt;
                                byte_valid <= 1'b1;
                                if (state == ADDR) begin
                                    addr_match <= (shift_nxt[7:1] == SLAVE_ADDR);
                                    rw_mode    <= shift_nxt[0];
                                    state      <= ADDR_ACK;
                                end else begin
                                    state <= DATA_ACK;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    ADDR_ACK, DATA_ACK: begin
                        if (!ack_window && !ack_done && scl_fall) begin
                            // A foreign address never opens an ACK window.
                            if (state == ADDR_ACK && !addr_match) begin
                                state <= IDLE;
                            end else begin
                                ack_window <= 1'b1;
                            end
                        end else if (ack_window && !ack_done && scl_rise) begin
                            ack_value   <= sda_s;
                            ack_sampled <= 1'b1;
                            ack_done    <= 1'b1;
                        end else if (ack_done && scl_fall) begin
                            ack_window <= 1'b0;
                            ack_done   <= 1'b0;
                            bit_cnt    <= 3'd0;
                            shift      <= 8'h00;
                            state      <= DATA;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_rx_detect.sv
// Scoreboard bench for i2c_rx_detect: bit-banged I2C master on the pads,
// expected bytes and ACK samples queued ahead and popped on output pulses.
module tb_i2c_rx_detect;

    localparam int Q = 6;

    typedef struct {
        logic [7:0] data;
        logic       match;
        logic       rw;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_in = 1'b1;
    logic       sda_in = 1'b1;
    logic [7:0] rx_data;
    logic       byte_valid;
    logic       start_found;
    logic       stop_found;
    logic       addr_match;
    logic       rw_mode;
    logic       ack_window;
    logic       ack_sampled;
    logic       ack_value;

    int n_tests = 0;
    int n_fail  = 0;
    int n_start = 0;
    int n_stop  = 0;
    int n_win   = 0;
    logic prev_bv  = 1'b0;
    logic prev_win = 1'b0;

    exp_t byte_q[$];
    logic ack_q[$];

    i2c_rx_detect #(.SLAVE_ADDR(7'b1111000)) dut (
        .clk        (clk),
        .rst        (rst),
        .scl_in     (scl_in),
        .sda_in     (sda_in),
        .rx_data    (rx_data),
        .byte_valid (byte_valid),
        .start_found(start_found),
        .stop_found (stop_found),
        .addr_match (addr_match),
        .rw_mode    (rw_mode),
        .ack_window (ack_window),
        .ack_sampled(ack_sampled),
        .ack_value  (ack_value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic i2c_start();
        sda_in = 1'b1;
        wait_clk(Q);
        scl_in = 1'b1;
        wait_clk(Q);
        sda_in = 1'b0;
        wait_clk(Q);
        scl_in = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_in = 1'b0;
        wait_clk(Q);
        scl_in = 1'b1;
        wait_clk(Q);
        sda_in = 1'b1;
        wait_clk(2 * Q);
    endtask

    task automatic i2c_bit(input logic b);
        sda_in = b;
        wait_clk(Q);
        scl_in = 1'b1;
        wait_clk(Q);
        scl_in = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_byte(input logic [7:0] b, input logic ack);
        for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
        i2c_bit(ack);
    endtask

    task automatic push_byte(input logic [7:0] d, input logic m, input logic rw);
        exp_t e;
        e.data  = d;
        e.match = m;
        e.rw    = rw;
        byte_q.push_back(e);
    endtask

    // Output monitor: pops the scoreboard on every byte and ACK pulse.
    always @(negedge clk) begin
        n_start += int'(start_found);
        n_stop  += int'(stop_found);
        if (ack_window && !prev_win) n_win++;
        if (byte_valid && prev_bv) chk("bv_width", 32'(prev_bv & byte_valid), 0);
        if (byte_valid) begin
            if (byte_q.size() == 0) begin
                chk("bv_unexpected", 32'(rx_data), 32'hFFFF);
            end else begin
                exp_t e;
                e = byte_q.pop_front();
                chk("rx_data", 32'(rx_data), 32'(e.data));
                chk("addr_match", 32'(addr_match), 32'(e.match));
                chk("rw_mode", 32'(rw_mode), 32'(e.rw));
            end
        end
        if (ack_sampled) begin
            chk("ack_win_at_sample", 32'(ack_window), 1);
            if (ack_q.size() == 0) begin
                chk("ack_unexpected", 32'(ack_value), 32'hFFFF);
            end else begin
                logic a;
                a = ack_q.pop_front();
                chk("ack_value", 32'(ack_value), 32'(a));
            end
        end
        prev_bv  = byte_valid;
        prev_win = ack_window;
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rx"}, 32'(rx_data), 0);
        chk({tag, "_flags"},
            32'({byte_valid, start_found, stop_found, addr_match,
                 rw_mode, ack_window, ack_sampled, ack_value}), 0);
    endtask

    initial begin
        int s0, p0, w0;
        wait_clk(4);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        rst = 1'b0;
        wait_clk(4);

        // Matched write of 0xA5, then STOP
        s0 = n_start; p0 = n_stop; w0 = n_win;
        i2c_start();
        push_byte(8'hF0, 1'b1, 1'b0);
        ack_q.push_back(1'b0);
        i2c_byte(8'hF0, 1'b0);
        chk("start_cnt_1", 32'(n_start - s0), 1);
        chk("win_cnt_addr", 32'(n_win - w0), 1);
        push_byte(8'hA5, 1'b1, 1'b0);
        ack_q.push_back(1'b0);
        i2c_byte(8'hA5, 1'b0);
        i2c_stop();
        chk("stop_cnt_1", 32'(n_stop - p0), 1);
        chk("match_after_stop", 32'(addr_match), 0);
        chk("win_after_stop", 32'(ack_window), 0);

        // Foreign address: no window, later clocks ignored
        s0 = n_start; p0 = n_stop; w0 = n_win;
        i2c_start();
        push_byte(8'h22, 1'b0, 1'b0);
        i2c_byte(8'h22, 1'b0);
        i2c_byte(8'h55, 1'b0);
        chk("win_cnt_foreign", 32'(n_win - w0), 0);
        chk("match_foreign", 32'(addr_match), 0);
        i2c_stop();
        chk("stop_in_idle", 32'(n_stop - p0), 1);

        // Partial byte then repeated START to a read address, NACKed byte
        s0 = n_start; p0 = n_stop;
        i2c_start();
        push_byte(8'hF0, 1'b1, 1'b0);
        ack_q.push_back(1'b0);
        i2c_byte(8'hF0, 1'b0);
        i2c_bit(1'b1); i2c_bit(1'b0); i2c_bit(1'b1); i2c_bit(1'b0);
        i2c_start();
        chk("start_cnt_rs", 32'(n_start - s0), 2);
        chk("match_after_rs", 32'(addr_match), 0);
        push_byte(8'hF1, 1'b1, 1'b1);
        ack_q.push_back(1'b0);
        i2c_byte(8'hF1, 1'b0);
        push_byte(8'h3C, 1'b1, 1'b1);
        ack_q.push_back(1'b1);
        i2c_byte(8'h3C, 1'b1);
        i2c_stop();
        chk("stop_cnt_rs", 32'(n_stop - p0), 1);

        // Reset mid-byte then a clean transaction
        i2c_start();
        i2c_bit(1'b1); i2c_bit(1'b1); i2c_bit(1'b1);
        s0 = n_start; p0 = n_stop;
        rst = 1'b1;
        scl_in = 1'b1;
        sda_in = 1'b1;
        wait_clk(3);
        @(negedge clk);
        chk_all_zero("midrst");
        @(posedge clk);
        rst = 1'b0;
        wait_clk(Q);
        chk("no_pulse_rst", 32'((n_start - s0) + (n_stop - p0)), 0);
        i2c_start();
        push_byte(8'hF0, 1'b1, 1'b0);
        ack_q.push_back(1'b0);
        i2c_byte(8'hF0, 1'b0);
        i2c_stop();

        wait_clk(4);
        chk("bytes_left", 32'(byte_q.size()), 0);
        chk("acks_left", 32'(ack_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
